pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage MIPS core. Drives write-enable/bubble/flush controls of PC,
//  IF/ID, ID/EX and EX/MEM registers: load-use stalls, taken-branch flushes, multi-cycle multiply

---
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the ID-stage sequencer and the pipeline
// registers it steers. The slave side is the sequencer itself.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_branch_taken;
  logic             id_halt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             ex_mul_start;
  logic             mem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_bubble;
  logic             exmem_write;
  logic             exmem_bubble;
  logic             mul_busy;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_branch_taken, id_halt,
           ex_mem_read, ex_rt, ex_mul_start, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_write, exmem_bubble, mul_busy, halted, stall_cycles
  );

  modport master (
    output id_rs, id_rt, id_uses_rt, id_branch_taken, id_halt,
           ex_mem_read, ex_rt, ex_mul_start, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_write, exmem_bubble, mul_busy, halted, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: load-use stalls, taken-branch
// flushes, multiply freezes, data-memory wait freezes and HALT drain.
// Enables are decoded from state and this cycle's inputs so the pipeline
// registers react in the same cycle the hazard is seen.
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int MC_W = $clog2(MUL_LAT);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MUL  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            r_state;
  logic [MC_W-1:0]   r_mul_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;

  state_t            w_next_state;
  logic [MC_W-1:0]   w_next_cnt;
  logic              w_load_use;
  logic              w_pc, w_ifw, w_ifl, w_idw, w_idb, w_exw, w_exb;
  logic              w_stall_inc;

  assign w_load_use = bus.ex_mem_read & (bus.ex_rt != 5'd0) &
                      ((bus.ex_rt == bus.id_rs) |
                       (bus.id_uses_rt & (bus.ex_rt == bus.id_rt)));

  // Decode pipeline enables and the next sequencer state from state + inputs.
  always_comb begin
    w_pc         = 1'b1;
    w_ifw        = 1'b1;
    w_ifl        = 1'b0;
    w_idw        = 1'b1;
    w_idb        = 1'b0;
    w_exw        = 1'b1;
    w_exb        = 1'b0;
    w_next_state = r_state;
    w_next_cnt   = r_mul_cnt;
    case (r_state)
      ST_RUN: begin
        if (bus.mem_busy) begin
          w_pc  = 1'b0;
          w_ifw = 1'b0;
          w_idw = 1'b0;
          w_exw = 1'b0;
        end else if (bus.ex_mul_start) begin
          w_pc         = 1'b0;
          w_ifw        = 1'b0;
          w_idw        = 1'b0;
          w_exb        = 1'b1;
          w_next_cnt   = MC_W'(MUL_LAT - 2);
          w_next_state = ST_MUL;
        end else if (w_load_use) begin
          // Single bubble: the load leaves EX next cycle and the hazard clears.
          w_pc  = 1'b0;
          w_ifw = 1'b0;
          w_idb = 1'b1;
        end else if (bus.id_halt) begin
          w_pc         = 1'b0;
          w_ifl        = 1'b1;
          w_next_state = ST_HALT;
        end else if (bus.id_branch_taken) begin
          w_ifl = 1'b1;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_MUL: begin
        // ID is frozen here, so its hazards are re-evaluated once back in RUN.
        if (bus.mem_busy) begin
          w_pc  = 1'b0;
          w_ifw = 1'b0;
          w_idw = 1'b0;
          w_exw = 1'b0;
        end else if (r_mul_cnt != {MC_W{1'b0}}) begin
          w_pc       = 1'b0;
          w_ifw      = 1'b0;
          w_idw      = 1'b0;
          w_exb      = 1'b1;
          w_next_cnt = r_mul_cnt - {{(MC_W-1){1'b0}}, 1'b1};
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_HALT: begin
        // Fetch is blocked forever; the later stages keep draining.
        w_pc  = 1'b0;
        w_ifw = 1'b0;
        w_ifl = 1'b1;
        if (bus.mem_busy) begin
          w_idw = 1'b0;
          w_exw = 1'b0;
        end else begin
          w_idw = 1'b1;
          w_exw = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_RUN;
        w_next_cnt   = {MC_W{1'b0}};
      end
    endcase
  end

  // Sequencer state and multiply down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_mul_cnt <= {MC_W{1'b0}};
    end else begin
      r_state   <= w_next_state;
      r_mul_cnt <= w_next_cnt;
    end
  end

  assign w_stall_inc = ~w_pc & (r_state != ST_HALT) &
                       (r_stall_cnt != {CNT_W{1'b1}});

  // Saturating count of fetch-stalled cycles outside HALT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (w_stall_inc) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  // While reset is held every pipeline register is told to hold its value.
  assign bus.pc_write     = w_pc  & ~rst;
  assign bus.ifid_write   = w_ifw & ~rst;
  assign bus.ifid_flush   = w_ifl & ~rst;
  assign bus.idex_write   = w_idw & ~rst;
  assign bus.idex_bubble  = w_idb & ~rst;
  assign bus.exmem_write  = w_exw & ~rst;
  assign bus.exmem_bubble = w_exb & ~rst;
  assign bus.mul_busy     = (r_state == ST_MUL);
  assign bus.halted       = (r_state == ST_HALT);
  assign bus.stall_cycles = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed table, corner-case
// sequences, then randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int MUL_LAT = 4;
  localparam int MAXC16  = 65535;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       br;
    logic       halt;
    logic       mrd;
    logic [4:0] ex_rt;
    logic       mul;
    logic       busy;
  } in_t;

  // pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, exmem_bubble
  typedef struct packed {
    logic pc; logic ifw; logic fl; logic idw; logic idb; logic exw; logic exb;
  } out_t;

  typedef struct {
    in_t   i;
    out_t  o;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

  pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave));

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: halted flag, multiply progress (0 = none), raw stall count
  bit m_halt = 1'b0;
  int m_age  = 0;
  int m_stalls = 0;

  in_t idle;

  function automatic in_t mk(input int rs, input int rt, input bit uses, input bit br,
                             input bit halt, input bit mrd, input int exrt,
                             input bit mul, input bit busy);
    in_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.uses_rt = uses; v.br = br; v.halt = halt;
    v.mrd = mrd; v.ex_rt = 5'(exrt); v.mul = mul; v.busy = busy;
    return v;
  endfunction

  task automatic drive(input in_t v);
    bus.id_rs = v.rs; bus.id_rt = v.rt; bus.id_uses_rt = v.uses_rt;
    bus.id_branch_taken = v.br; bus.id_halt = v.halt; bus.ex_mem_read = v.mrd;
    bus.ex_rt = v.ex_rt; bus.ex_mul_start = v.mul; bus.mem_busy = v.busy;
  endtask

  task automatic drive4(input in_t v);
    bus4.id_rs = v.rs; bus4.id_rt = v.rt; bus4.id_uses_rt = v.uses_rt;
    bus4.id_branch_taken = v.br; bus4.id_halt = v.halt; bus4.ex_mem_read = v.mrd;
    bus4.ex_rt = v.ex_rt; bus4.ex_mul_start = v.mul; bus4.mem_busy = v.busy;
  endtask

  function automatic out_t get_out();
    return {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_write,
            bus.idex_bubble, bus.exmem_write, bus.exmem_bubble};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic bit is_lu(input in_t v);
    return v.mrd && (v.ex_rt != 5'd0) &&
           ((v.ex_rt == v.rs) || (v.uses_rt && (v.ex_rt == v.rt)));
  endfunction

  // Expected enables from the sequencing rules for the current model state.
  function automatic out_t ref_out(input in_t v);
    out_t o;
    o = 7'b1101010;
    if (m_halt) begin
      o.pc = 1'b0; o.ifw = 1'b0; o.fl = 1'b1;
      if (v.busy) begin o.idw = 1'b0; o.exw = 1'b0; end
    end else if (v.busy) begin
      o = 7'b0000000;
    end else if (m_age > 0) begin
      if (m_age < MUL_LAT - 1) begin
        o.pc = 1'b0; o.ifw = 1'b0; o.idw = 1'b0; o.exb = 1'b1;
      end
    end else if (v.mul) begin
      o.pc = 1'b0; o.ifw = 1'b0; o.idw = 1'b0; o.exb = 1'b1;
    end else if (is_lu(v)) begin
      o.pc = 1'b0; o.ifw = 1'b0; o.idb = 1'b1;
    end else if (v.halt) begin
      o.pc = 1'b0; o.fl = 1'b1;
    end else if (v.br) begin
      o.fl = 1'b1;
    end
    return o;
  endfunction

  task automatic ref_update(input in_t v, input out_t e);
    if (!m_halt && !e.pc) m_stalls++;
    if (m_halt) begin
    end else if (m_age > 0) begin
      if (!v.busy) m_age = (m_age < MUL_LAT - 1) ? m_age + 1 : 0;
    end else if (v.busy) begin
    end else if (v.mul) begin
      m_age = 1;
    end else if (is_lu(v)) begin
    end else if (v.halt) begin
      m_halt = 1'b1;
    end
  endtask

  // One clock cycle on the main DUT, compared against the model.
  task automatic step(input in_t v, input string nm);
    out_t e;
    int   sat;
    @(negedge clk);
    drive(v);
    #1;
    e   = ref_out(v);
    sat = (m_stalls > MAXC16) ? MAXC16 : m_stalls;
    chk({nm, "_enables"}, 32'(get_out()), 32'(e));
    chk({nm, "_mul_busy"}, 32'(bus.mul_busy), 32'(m_age > 0));
    chk({nm, "_halted"}, 32'(bus.halted), 32'(m_halt));
    chk({nm, "_stall_cycles"}, 32'(bus.stall_cycles), 32'(sat));
    ref_update(v, e);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    drive(idle);
    drive4(idle);
    rst = 1'b1;
    #1;
    chk({nm, "_rst_enables"}, 32'(get_out()), 32'd0);
    chk({nm, "_rst_mul_busy"}, 32'(bus.mul_busy), 32'd0);
    chk({nm, "_rst_halted"}, 32'(bus.halted), 32'd0);
    chk({nm, "_rst_stall"}, 32'(bus.stall_cycles), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_halt = 1'b0; m_age = 0; m_stalls = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[10];
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    drive4(idle);

    tbl[0] = '{mk(1, 2, 1, 0, 0, 0, 0, 0, 0), 7'b1101010, "tbl_idle"};
    tbl[1] = '{mk(1, 2, 1, 0, 0, 0, 0, 0, 1), 7'b0000000, "tbl_busy"};
    tbl[2] = '{mk(3, 4, 0, 0, 0, 1, 3, 0, 0), 7'b0001110, "tbl_lu_rs"};
    tbl[3] = '{mk(1, 7, 1, 0, 0, 1, 7, 0, 0), 7'b0001110, "tbl_lu_rt"};
    tbl[4] = '{mk(1, 7, 0, 0, 0, 1, 7, 0, 0), 7'b1101010, "tbl_rt_unused"};
    tbl[5] = '{mk(0, 0, 1, 0, 0, 1, 0, 0, 0), 7'b1101010, "tbl_r0"};
    tbl[6] = '{mk(1, 2, 0, 1, 0, 0, 0, 0, 0), 7'b1111010, "tbl_branch"};
    tbl[7] = '{mk(6, 2, 0, 1, 0, 1, 6, 0, 0), 7'b0001110, "tbl_lu_branch"};
    tbl[8] = '{mk(6, 2, 0, 1, 0, 1, 6, 0, 1), 7'b0000000, "tbl_busy_lu_br"};
    tbl[9] = '{mk(6, 6, 1, 0, 0, 0, 6, 0, 0), 7'b1101010, "tbl_no_load"};

    do_reset("init");

    // directed table, all rows stay in RUN
    for (int k = 0; k < 10; k++) begin
      step(tbl[k].i, tbl[k].name);
      chk({tbl[k].name, "_table"}, 32'(get_out()), 32'(tbl[k].o));
    end

    // T1: reset in the middle of a multiply
    do_reset("t1a");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), "t1_mul");
    step(idle, "t1_f2");
    step(idle, "t1_f3");
    chk("t1_mul_busy_before_rst", 32'(bus.mul_busy), 32'd1);
    do_reset("t1");

    // T2: load-use stall and its non-stalling neighbours
    step(mk(5, 0, 0, 0, 0, 1, 5, 0, 0), "t2_lu");
    step(idle, "t2_after");
    chk("t2_stall_one", 32'(bus.stall_cycles), 32'd1);
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0), "t2_r0");
    step(mk(1, 5, 0, 0, 0, 1, 5, 0, 0), "t2_rt_unused");
    step(idle, "t2_end");
    chk("t2_stall_still_one", 32'(bus.stall_cycles), 32'd1);

    // T3: plain multiply freezes three cycles
    do_reset("t3");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), "t3_mul");
    step(idle, "t3_f2");
    step(idle, "t3_f3");
    step(idle, "t3_adv");
    chk("t3_adv_pc_write", 32'(bus.pc_write), 32'd1);
    chk("t3_stall_three", 32'(bus.stall_cycles), 32'd3);

    // T4: memory wait inside the multiply at cnt=1
    do_reset("t4");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), "t4_mul");
    step(idle, "t4_f2");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), "t4_busy1");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), "t4_busy2");
    step(idle, "t4_f3");
    step(idle, "t4_adv");
    chk("t4_stall_five", 32'(bus.stall_cycles), 32'd5);

    // T5: load-use beats a taken branch, branch flushes next cycle
    do_reset("t5");
    step(mk(9, 0, 0, 1, 0, 1, 9, 0, 0), "t5_lu_br");
    chk("t5_bubble", 32'(bus.idex_bubble), 32'd1);
    chk("t5_no_flush", 32'(bus.ifid_flush), 32'd0);
    step(mk(9, 0, 0, 1, 0, 0, 0, 0, 0), "t5_br");
    chk("t5_flush", 32'(bus.ifid_flush), 32'd1);

    // T6: HALT drains for 100 cycles, stall count frozen after entry
    do_reset("t6");
    step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0), "t6_halt");
    for (int k = 0; k < 100; k++) begin
      step(mk(0, 0, 0, k[0], 0, 0, 0, k[1], (k % 7) == 3), "t6_drain");
    end
    chk("t6_halted", 32'(bus.halted), 32'd1);
    chk("t6_stall_frozen", 32'(bus.stall_cycles), 32'd1);
    do_reset("t6_exit");
    chk("t6_run_after_rst", 32'(bus.halted), 32'd0);

    // T7: 4-bit counter saturates
    for (int k = 0; k < 20; k++) begin
      drive4(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
      step(idle, "t7_main_idle");
    end
    chk("t7_saturated", 32'(bus4.stall_cycles), 32'd15);
    drive4(idle);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      in_t v;
      if ($urandom_range(0, 79) == 0) begin
        do_reset("rnd");
      end else begin
        v.rs      = 5'($urandom_range(0, 3));
        v.rt      = 5'($urandom_range(0, 3));
        v.uses_rt = 1'($urandom_range(0, 1));
        v.br      = ($urandom_range(0, 3) == 0);
        v.halt    = ($urandom_range(0, 39) == 0);
        v.mrd     = ($urandom_range(0, 2) == 0);
        v.ex_rt   = 5'($urandom_range(0, 3));
        v.mul     = ($urandom_range(0, 9) == 0);
        v.busy    = ($urandom_range(0, 3) == 0);
        step(v, "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
